// File: rtl/bitty_sequencer_if.sv
// bitty_sequencer_if: instruction fetch request/acknowledge port between sequencer and memory
interface bitty_sequencer_if #(
    parameter int PC_WIDTH = 8
);
    logic                fetch_req;
    logic [PC_WIDTH-1:0] pc;
    logic                fetch_ack;
    logic [15:0]         fetch_data;
    modport master (output fetch_req, output pc, input fetch_ack, input fetch_data);
    modport slave  (input fetch_req, input pc, output fetch_ack, output fetch_data);
endinterface

// File: rtl/bitty_sequencer.sv
// bitty_sequencer: fetches instructions and drives Bitty datapath enables in fixed order
module bitty_sequencer #(
    parameter int PC_WIDTH  = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    bitty_sequencer_if.master    fetch,
    output logic [15:0]          instruction,
    output logic                 en_i,
    output logic                 en_s,
    output logic                 en_c,
    output logic [7:0]           en_reg,
    output logic                 busy,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] retired
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] FETCH     = 3'd1;
    localparam logic [2:0] DECODE    = 3'd2;
    localparam logic [2:0] SETUP     = 3'd3;
    localparam logic [2:0] EXEC      = 3'd4;
    localparam logic [2:0] WRITEBACK = 3'd5;
    localparam logic [2:0] HALTED    = 3'd6;

    logic [2:0]           state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [15:0]          instr_q, instr_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;
    logic                 is_halt;

    assign is_halt = fetch.fetch_data[1:0] == 2'b11;

    // next-state: a halt word never reaches the instruction register
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        case (state_q)
            IDLE, HALTED: if (start) begin
                state_d   = FETCH;
                pc_d      = '0;
                retired_d = '0;
            end
            FETCH: if (fetch.fetch_ack) begin
                state_d = is_halt ? HALTED : DECODE;
                instr_d = is_halt ? instr_q : fetch.fetch_data;
            end
            DECODE:    state_d = SETUP;
            SETUP:     state_d = EXEC;
            EXEC:      state_d = WRITEBACK;
            WRITEBACK: begin
                state_d   = FETCH;
                pc_d      = pc_q + 1'b1;
                retired_d = retired_q + 1'b1;
            end
            default:   state_d = IDLE;
        endcase
    end

    // state registers; reset overrides start and fetch_ack
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            instr_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    assign fetch.fetch_req = state_q == FETCH;
    assign fetch.pc        = pc_q;
    assign instruction     = instr_q;
    assign en_i            = state_q == DECODE;
    assign en_s            = state_q == SETUP;
    assign en_c            = state_q == EXEC;
    assign en_reg          = (state_q == WRITEBACK) ? 8'd1 << instr_q[15:13] : 8'd0;
    assign busy            = state_q != IDLE && state_q != HALTED;
    assign halted          = state_q == HALTED;
    assign retired         = retired_q;
endmodule
